// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int n_bit = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [n_bit-1:0] a,
    input  logic [n_bit-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [n_bit-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int cnt_w = (n_bit > 1) ? $clog2(n_bit) : 1;
    localparam logic [cnt_w-1:0] last_bit = cnt_w'(n_bit - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [n_bit-1:0] a_q, a_d;
    logic [n_bit-1:0] b_q, b_d;
    logic [n_bit-1:0] res_q, res_d;
    logic [n_bit-1:0] diff_q, diff_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             borrow_out_q, borrow_out_d;
    logic             ovf_q, ovf_d;
    logic             bit_diff;
    logic             bit_borrow;

    // Operand registers shift right so the bit under work is always at index 0.
    assign bit_diff   = a_q[0] ^ b_q[0] ^ br_q;
    assign bit_borrow = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        br_d         = br_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        borrow_out_d = borrow_out_q;
        ovf_d        = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = borrow_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = bit_borrow;
                res_d  = {bit_diff, res_q[n_bit-1:1]};
                cnt_d  = cnt_q + cnt_w'(1);
                busy_d = 1'b1;
                if (cnt_q == last_bit) begin
                    // Results are published only here, so partial values never leak out.
                    diff_d       = {bit_diff, res_q[n_bit-1:1]};
                    borrow_out_d = bit_borrow;
                    ovf_d        = br_q ^ bit_borrow;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            br_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            borrow_out_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            br_q         <= br_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            borrow_out_q <= borrow_out_d;
            ovf_q        <= ovf_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;

`ifdef SERIAL_SUB_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (n_bit=8); ovf checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int n_bit = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [n_bit-1:0] a;
    logic [n_bit-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [n_bit-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [n_bit-1:0] held_diff = '0;
    logic             held_bo   = 1'b0;
    logic             held_ovf  = 1'b0;

    serial_subtractor #(.n_bit(n_bit)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called just after a negedge so the inputs are stable at the next rising edge.
    task automatic applyStimulus(input logic [n_bit-1:0] a_v, input logic [n_bit-1:0] b_v,
                                 input logic bin_v);
        start     = 1'b1;
        a         = a_v;
        b         = b_v;
        borrow_in = bin_v;
    endtask

    // Follows one operation whose start is already driven; glitch_at injects a start pulse
    // during SHIFT, chain launches the next operation in the DONE cycle.
    task automatic runOp(input string tag, input logic [n_bit-1:0] exp_diff, input logic exp_bo,
                         input logic exp_ovf, input int glitch_at, input logic chain,
                         input logic [n_bit-1:0] next_a, input logic [n_bit-1:0] next_b);
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
        checkOutput({tag, "_diff_held_first"}, {24'd0, diff}, {24'd0, held_diff});
        for (int k = 1; k < n_bit; k++) begin
            if (k == glitch_at) begin
                applyStimulus(8'd1, 8'd1, 1'b1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            checkOutput({tag, "_busy_mid"}, {30'd0, busy, done}, 32'b10);
            checkOutput({tag, "_hold_mid"}, {23'd0, borrow_out, diff}, {23'd0, held_bo, held_diff});
        end
        start = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_done"}, {30'd0, busy, done}, 32'b01);
        checkOutput({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_diff});
        checkOutput({tag, "_borrow_out"}, {31'd0, borrow_out}, {31'd0, exp_bo});
`ifdef SERIAL_SUB_OVF_EN
        checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`endif
        held_diff = exp_diff;
        held_bo   = exp_bo;
        held_ovf  = exp_ovf;
        if (chain) begin
            applyStimulus(next_a, next_b, 1'b0);
        end else begin
            @(negedge clk);
            checkOutput({tag, "_after"}, {30'd0, busy, done}, 32'b00);
            checkOutput({tag, "_after_diff"}, {23'd0, borrow_out, diff}, {23'd0, held_bo, held_diff});
        end
    endtask

    initial begin
        logic saw_done;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_diff", {24'd0, diff}, 32'd0);
        checkOutput("reset_borrow_out", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        applyStimulus(8'd100, 8'd37, 1'b0);
        runOp("op_100_37", 8'd63, 1'b0, 1'b0, 0, 1'b0, '0, '0);

        applyStimulus(8'd5, 8'd9, 1'b0);
        runOp("op_5_9", 8'd252, 1'b1, 1'b0, 0, 1'b0, '0, '0);

        applyStimulus(8'd0, 8'd0, 1'b1);
        runOp("op_0_0_bin", 8'd255, 1'b1, 1'b0, 0, 1'b0, '0, '0);

        applyStimulus(8'd200, 8'd50, 1'b0);
        runOp("op_200_50_glitch", 8'd150, 1'b0, 1'b0, 3, 1'b1, 8'd10, 8'd3);
        runOp("op_10_3_chain", 8'd7, 1'b0, 1'b0, 0, 1'b0, '0, '0);

        applyStimulus(8'd0, 8'd255, 1'b1);
        runOp("op_0_255_bin", 8'd0, 1'b1, 1'b0, 0, 1'b0, '0, '0);

        applyStimulus(8'h80, 8'h01, 1'b0);
        runOp("op_80_01", 8'h7F, 1'b0, 1'b1, 0, 1'b0, '0, '0);

        applyStimulus(8'h10, 8'h01, 1'b0);
        runOp("op_10_01", 8'h0F, 1'b0, 1'b0, 0, 1'b0, '0, '0);

        // Abort an operation after bits 0..3 have been processed.
        applyStimulus(8'd100, 8'd37, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_state", {22'd0, busy, done, borrow_out, diff}, 32'd0);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < n_bit + 4; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", {31'd0, saw_done}, 32'd0);
        checkOutput("abort_diff_held", {24'd0, diff}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial subtractor computing a - b - borrow_in over n_bit clock cycles, LSB first.
- It is the inverse operation of the team's ripple-carry full adder. It is used where area matters more than latency and multi-cycle arithmetic is acceptable.
- Start/done handshake: operands are latched on start, the result is presented with a one-cycle done pulse, and the result is held until the next operation completes.

Parameters:
- n_bit, 8, operand/result width in bits (must be >= 2)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only when busy=0
- a  input  n_bit  minuend, latched when start is accepted
- b  input  n_bit  subtrahend, latched when start is accepted
- borrow_in  input  1  borrow into bit 0, latched when start is accepted
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse, result valid
- diff  output  n_bit  result a - b - borrow_in (mod 2^n_bit)
- borrow_out  output  1  borrow out of the MSB (1 = unsigned underflow)

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal operand/shift registers, bit counter and borrow flop cleared.
  - Reset has priority over everything, including mid-SHIFT; the operation in progress is discarded and no done is produced.
- IDLE:
  - busy=0, done=0.
  - start=1 -> latch a, b, borrow_in into the internal borrow flop; bit counter=0; go to SHIFT.
- SHIFT:
  - busy=1. One bit per cycle, bit i = counter.
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br).
  - d_i goes into an internal result shift register; br is updated; counter increments.
  - start is ignored. Changes on a/b/borrow_in have no effect.
- SHIFT -> DONE:
  - On the edge processing bit n_bit-1: copy the internal result to diff, final br to borrow_out, set done=1, busy=0.
- DONE:
  - Lasts exactly one cycle with done=1.
  - start=1 -> accept new operands, go to SHIFT (back-to-back; no idle gap required).
  - Otherwise go to IDLE.
- Latency:
  - start sampled at edge E0 -> done high after edge E0+n_bit. Busy spans the n_bit cycles in between.
  - Throughput: one operation per n_bit+1 cycles minimum.
- Output stability:
  - diff/borrow_out change only on the SHIFT->DONE edge and on reset.
  - They hold their values through IDLE and through the following operation's SHIFT phase. Partial results are never visible.
- Arithmetic:
  - Unsigned modulo 2^n_bit.
  - borrow_out=1 iff a < b + borrow_in (unsigned).
  - Result is bit-exact with {borrow_out, diff} = {1'b0, a} - {1'b0, b} - borrow_in, taken in n_bit+1-bit two's complement.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow of a - b - borrow_in.
  - ovf = (borrow into MSB) XOR (borrow out of MSB), captured on the bit n_bit-1 edge.
  - Updated together with diff. Reset value 0; held like diff.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then start with a=100, b=37, borrow_in=0 (n_bit=8) -> busy=1 for 8 cycles; done pulse 8 edges after the start edge; diff=63, borrow_out=0.
- a=5, b=9, borrow_in=0 -> diff=252, borrow_out=1. Then a=0, b=0, borrow_in=1 -> diff=255, borrow_out=1.
- Mid-SHIFT start pulse with a=1, b=1 -> ignored; the running op (a=200, b=50) completes with diff=150; only one done pulse.
- start held high in the DONE cycle with a=10, b=3 -> no IDLE cycle; next done exactly 8 edges later with diff=7. Previous diff held until then.
- rst_n=0 at bit 4 of an op -> next edge shows busy=0, done=0, diff=0; no done ever issued for the aborted op.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1, borrow_out=0. a=0x10, b=0x01 -> ovf=0.
